mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's initiator bus (mem_read / mem_write / mem_byte_enable / mem_resp).
- Services one request at a time from an internal word array, with programmable latency.
- Byte-enabled writes; returns full-word read data.
- Sits behind the CPU control/datapath, in the bench top or the synthesized top, replacing the magic memory.

Parameters:
- LATENCY, 2, cycles from request accept to mem_resp; legal range 1..15.
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- BASE_ADDR, 32'h0000_0000, byte address that maps to word 0.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- mem_address  in  32  byte address; bits [1:0] ignored, word index = (mem_address - BASE_ADDR) >> 2
- mem_read  in  1  read request; held by the initiator until mem_resp
- mem_write  in  1  write request; held by the initiator until mem_resp
- mem_byte_enable  in  4  per-byte write mask; ignored for reads
- mem_wdata  in  32  write data, already lane-aligned by the initiator
- mem_rdata  out  32  read data; valid only in the mem_resp cycle
- mem_resp  out  1  one-cycle completion pulse
- mem_err  out  1  one-cycle pulse coincident with mem_resp on an erroneous request

Behaviour:
- Reset is synchronous and active-high on rst, clocked by clk.
- Reset values: state=IDLE, mem_resp=0, mem_err=0, mem_rdata=0, latency counter=0.
- Array contents are not cleared by reset and are retained across a mid-operation reset.
- States:
  - IDLE: when (mem_read|mem_write)=1, accept the request. Capture address, byte enables, wdata and type; load cnt=LATENCY-1; go to BUSY, or straight to RESP if LATENCY=1.
  - BUSY: decrement cnt each cycle. When cnt=0, go to RESP. On the transition edge, register the array word into mem_rdata (reads only).
  - RESP: mem_resp=1 for exactly one cycle, then IDLE unconditionally.
- The responder does not accept a new request in the RESP cycle. The held request is considered consumed.
- Back-to-back accept is possible on the first IDLE cycle after RESP.
- Latency: accept at cycle N, mem_resp at cycle N+LATENCY.
- Write commit: on the accept edge, for each i where be[i]=1, byte i of the word is updated. Bytes with be[i]=0 are untouched. be=0000 is a legal no-op write that still responds.
- Read-after-write: a read accepted after the write's RESP returns the new data.
- Error cases; each still completes with mem_resp so the initiator never hangs:
  - mem_read and mem_write both 1 at accept: treat as write, mem_err=1 in RESP.
  - Word index >= DEPTH_WORDS, or address < BASE_ADDR: write dropped, mem_rdata=0, mem_err=1.
  - Request deasserted during BUSY (protocol violation): transaction still completes, mem_err=1 in RESP.
- Captured request fields are the only ones used. Input changes during BUSY have no effect.
- Outside RESP, mem_rdata holds its last value; the verifier must not check it.

Optional Feature:
- Macro: MEM_RESPONDER_JITTER_EN.
- With the macro defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every clock.
  - At accept, latency = LATENCY + lfsr[2:0], i.e. LATENCY..LATENCY+7.
  - Exercises the initiator's wait loops.
- Without the macro: latency is fixed at LATENCY and no LFSR logic is present.

Decomposition:
- Package mem_responder_types:
  - state enum {IDLE, BUSY, RESP}
  - LFSR seed and tap constants
  - latency counter width localparam (4 bits, 5 with jitter)
- Sub-module mem_bank: DEPTH_WORDS x 32 array with a registered read port and a byte-enabled write port.
- The FSM, decode and error logic stay in mem_responder.

Test Plan:
- Reset, LATENCY=2: rst=1 for 2 cycles -> mem_resp=0, mem_err=0, mem_rdata=0.
- Full-word round trip:
  - write addr 0x10, be=1111, wdata=0xDEADBEEF -> mem_resp exactly 2 cycles after accept, mem_err=0.
  - then read 0x10 -> mem_rdata=0xDEADBEEF in the resp cycle.
- Byte-lane write:
  - preload 0x20=0x11223344.
  - write 0x22, be=0100, wdata=0x00AA0000 -> readback 0x11AA3344.
  - write be=0000 -> still 0x11AA3344, mem_resp seen.
- Back-to-back: read 0x10 held until resp, new read 0x20 asserted the next cycle -> second mem_resp at accept+2; exactly two resp pulses, no duplicate.
- Errors:
  - read at BASE_ADDR + 4*DEPTH_WORDS -> mem_resp=1, mem_err=1, mem_rdata=0.
  - read and write both high -> treated as write, mem_err=1.
- Reset mid-BUSY:
  - assert rst one cycle after accepting a read -> no mem_resp, state IDLE.
  - prior write data at 0x10 still reads 0xDEADBEEF.
  - with MEM_RESPONDER_JITTER_EN, 100 reads all complete, each with latency in 2..9.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice.
//
// Contents:
//   state_t / IDLE, BUSY, RESP : responder FSM encoding
//   LFSR_SEED, LFSR_TAPS       : latency-jitter LFSR reset value and feedback taps
//   CNT_W                      : latency counter width
//
// Build option: MEM_RESPONDER_JITTER_EN widens the latency counter so that
// LATENCY + 7 still fits.

package mem_responder_types;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t RESP = 2'd2;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

`ifdef MEM_RESPONDER_JITTER_EN
    localparam int unsigned CNT_W = 5;
`else
    localparam int unsigned CNT_W = 4;
`endif

endpackage

// File: rtl/mem_responder_bank.sv
// mem_bank: DEPTH_WORDS x 32 storage for mem_responder.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears the read register only)
//   we, waddr     : write strobe and word index
//   be, wdata     : per-byte write mask and lane-aligned write data
//   re, raddr     : registered read strobe and word index
//   rclr          : forces the read register to zero (out-of-range reads)
//   rdata         : registered read data, holds between reads
//
// The array itself is never reset so contents survive a reset.

module mem_bank #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic          rclr,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (rclr) begin
            rdata_q <= 32'h0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU initiator bus.
// Services one request at a time with a programmable accept-to-response latency.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   mem_address      : byte address, word index = (mem_address - BASE_ADDR) >> 2
//   mem_read         : read request, held until mem_resp
//   mem_write        : write request, held until mem_resp
//   mem_byte_enable  : per-byte write mask
//   mem_wdata        : lane-aligned write data
//   mem_rdata        : read data, valid in the mem_resp cycle only
//   mem_resp         : one-cycle completion pulse
//   mem_err          : error flag, coincident with mem_resp
//
// Build option: MEM_RESPONDER_JITTER_EN adds 0..7 pseudo-random cycles of latency
// per request from a free-running 16-bit LFSR.

module mem_responder
    import mem_responder_types::*;
#(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] acc_lat;
    logic [AW-1:0]    idx_q;
    logic             write_q, rerr_q, err_q;

    logic [32:0]      offset;
    logic             range_err, req, accept, in_idle, enter_resp;
    logic [AW-1:0]    in_idx, cur_idx;
    logic             cur_write, cur_rerr;
    logic             bank_we, bank_re, bank_rclr;
    logic             unused_addr_bits;

    // Extra borrow bit flags addresses below BASE_ADDR.
    assign offset           = {1'b0, mem_address} - {1'b0, BASE_ADDR};
    assign range_err        = offset[32] | (|offset[31:AW+2]);
    assign in_idx           = offset[AW+1:2];
    assign unused_addr_bits = ^offset[1:0];

    assign req     = mem_read | mem_write;
    assign in_idle = (state_q == IDLE);
    assign accept  = in_idle & req;

`ifdef MEM_RESPONDER_JITTER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign acc_lat = CNT_W'(LATENCY) + CNT_W'(lfsr_q[2:0]);
`else
    assign acc_lat = CNT_W'(LATENCY);
`endif

    // cnt holds the BUSY cycles still to go; RESP follows the cycle where it hits 1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d = acc_lat - CNT_W'(1);
                    if (acc_lat == CNT_W'(1)) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With a one-cycle latency the read happens on the accept edge, so take the
    // live request fields instead of the captured ones.
    assign cur_write = in_idle ? mem_write : write_q;
    assign cur_rerr  = in_idle ? range_err : rerr_q;
    assign cur_idx   = in_idle ? in_idx    : idx_q;

    assign bank_we   = accept & mem_write & ~range_err & ~rst;
    assign bank_re   = enter_resp & ~cur_write & ~cur_rerr;
    assign bank_rclr = enter_resp & ~cur_write & cur_rerr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            rerr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= in_idx;
                write_q <= mem_write;
                rerr_q  <= range_err;
                err_q   <= range_err | (mem_read & mem_write);
            end else if ((state_q == BUSY) && !req) begin
                // Initiator dropped its request early; still complete, but flag it.
                err_q <= 1'b1;
            end
        end
    end

    mem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we),
        .waddr (in_idx),
        .be    (mem_byte_enable),
        .wdata (mem_wdata),
        .re    (bank_re),
        .rclr  (bank_rclr),
        .raddr (cur_idx),
        .rdata (mem_rdata)
    );

    assign mem_resp = (state_q == RESP);
    assign mem_err  = mem_resp & err_q;

endmodule
